waveform_sequencer: RTL and testbench

Round-robin playback scheduler for the four waveform ROMs in the signal generator datapath. It decides which ROM plays, generates the ROM read address at a prescaled sample rate, and registers the selected sample onto the DAC path. When a waveform ends, the next requested waveform starts seamlessly. The block sits between the front-panel switch latches and the ROM bank, ahead of the output register stage.

---
 rtl/waveform_sequencer.sv | 164 ++++++++++++++++
 tb/tb_waveform_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_sequencer.sv
// Round-robin playback scheduler for four waveform ROMs.
// Generates a prescaled ROM address and registers the gated sample.
module waveform_sequencer #(
  parameter int PRESCALE = 11,
  parameter int LEN0     = 132,
  parameter int LEN1     = 121,
  parameter int LEN2     = 88,
  parameter int LEN3     = 55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [7:0] rom_data0,
  input  logic [7:0] rom_data1,
  input  logic [7:0] rom_data2,
  input  logic [7:0] rom_data3,
  output logic [7:0] rom_addr,
  output logic [1:0] sel,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic       wrap,
  output logic       busy
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t     state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [1:0] last_q, last_d;
  logic [7:0] addr_d;
  logic [1:0] sel_d;
  logic [7:0] so_d;
  logic       sv_d, wrap_d, busy_d;

  logic [7:0] rom_sel;
  logic [7:0] end_addr;
  logic [2:0] gnt_idle, gnt_end;
  logic       tick;

  // First set req bit after base, wrapping round to base itself last.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    rom_sel  = rom_data0;
    end_addr = 8'(LEN0 - 1);
    unique case (sel)
      2'd0: begin
        rom_sel  = rom_data0;
        end_addr = 8'(LEN0 - 1);
      end
      2'd1: begin
        rom_sel  = rom_data1;
        end_addr = 8'(LEN1 - 1);
      end
      2'd2: begin
        rom_sel  = rom_data2;
        end_addr = 8'(LEN2 - 1);
      end
      2'd3: begin
        rom_sel  = rom_data3;
        end_addr = 8'(LEN3 - 1);
      end
    endcase
  end

  assign gnt_idle = pick(req, last_q);
  assign gnt_end  = pick(req, sel);
  assign tick     = (pcnt_q == 8'(PRESCALE - 1));

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    last_d  = last_q;
    addr_d  = rom_addr;
    sel_d   = sel;
    so_d    = sample_out;
    sv_d    = 1'b0;
    wrap_d  = 1'b0;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        if (enable && gnt_idle[2]) begin
          state_d = PLAY;
          sel_d   = gnt_idle[1:0];
          last_d  = gnt_idle[1:0];
          addr_d  = 8'd0;
          pcnt_d  = 8'd0;
          busy_d  = 1'b1;
        end
      end
      PLAY: begin
        if (!enable) begin
          state_d = IDLE;
          addr_d  = 8'd0;
          pcnt_d  = 8'd0;
          busy_d  = 1'b0;
          so_d    = 8'h00;
          last_d  = sel;
        end else begin
          pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
          // ROM data for this address is valid one clock after pcnt=0.
          if (pcnt_q == 8'd1) begin
            sv_d = 1'b1;
            so_d = mask[sel] ? rom_sel : 8'h00;
          end
          if (tick) begin
            if (rom_addr == end_addr) begin
              addr_d = 8'd0;
              wrap_d = 1'b1;
              if (gnt_end[2]) begin
                sel_d  = gnt_end[1:0];
                last_d = gnt_end[1:0];
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              addr_d = rom_addr + 8'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= 8'd0;
      last_q       <= 2'd3;
      rom_addr     <= 8'd0;
      sel          <= 2'd0;
      sample_out   <= 8'h00;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      last_q       <= last_d;
      rom_addr     <= addr_d;
      sel          <= sel_d;
      sample_out   <= so_d;
      sample_valid <= sv_d;
      wrap         <= wrap_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer: vector tables plus
// hand-written sequences for handover, mask, enable drop and reset.
module tb_waveform_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic [3:0] mask;
  logic [7:0] rd0, rd1, rd2, rd3;
  logic [7:0] rom_addr;
  logic [1:0] sel;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       wrap;
  logic       busy;

  waveform_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .mask         (mask),
    .rom_data0    (rd0),
    .rom_data1    (rd1),
    .rom_data2    (rd2),
    .rom_data3    (rd3),
    .rom_addr     (rom_addr),
    .sel          (sel),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .wrap         (wrap),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [7:0] addr;
    logic       busy;
    logic       sv;
    logic       wrap;
    logic [7:0] so;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = -1;
  int   cad_bad = 0;
  bit   cad_on = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic chk(input logic [1:0] s, input logic [7:0] a,
                     input logic b, input logic v, input logic w,
                     input logic [7:0] so);
    cmp("sel", 32'(sel), 32'(s));
    cmp("rom_addr", 32'(rom_addr), 32'(a));
    cmp("busy", 32'(busy), 32'(b));
    cmp("sample_valid", 32'(sample_valid), 32'(v));
    cmp("wrap", 32'(wrap), 32'(w));
    cmp("sample_out", 32'(sample_out), 32'(so));
  endtask

  // cyc counts edges since the grant edge; checks sit on negedges.
  task automatic adv_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cad_on && (sample_valid !== ((cyc % 11) == 2)))
        cad_bad++;
    end
  endtask

  function automatic void add(input int c, input logic [1:0] s,
                              input logic [7:0] a, input logic b,
                              input logic v, input logic w,
                              input logic [7:0] so);
    vec_t t;
    t.cyc = c; t.sel = s; t.addr = a; t.busy = b;
    t.sv = v; t.wrap = w; t.so = so;
    tv.push_back(t);
  endfunction

  task automatic run_tv();
    foreach (tv[i]) begin
      adv_to(tv[i].cyc);
      chk(tv[i].sel, tv[i].addr, tv[i].busy,
          tv[i].sv, tv[i].wrap, tv[i].so);
    end
    tv.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    req = 4'h0;
    mask = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start(input logic [3:0] r);
    enable = 1'b1;
    req = r;
    cyc = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    req = 4'h0;
    mask = 4'hF;
    rd0 = 8'h5A;
    rd1 = 8'hB1;
    rd2 = 8'hC2;
    rd3 = 8'hD3;
    #1;
    chk(2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Single waveform 0, replayed.
    do_reset();
    start(4'b0001);
    add(0,    2'd0, 8'd0,   1, 0, 0, 8'h00);
    add(1,    2'd0, 8'd0,   1, 0, 0, 8'h00);
    add(2,    2'd0, 8'd0,   1, 1, 0, 8'h5A);
    add(3,    2'd0, 8'd0,   1, 0, 0, 8'h5A);
    add(11,   2'd0, 8'd1,   1, 0, 0, 8'h5A);
    add(13,   2'd0, 8'd1,   1, 1, 0, 8'h5A);
    add(1451, 2'd0, 8'd131, 1, 0, 0, 8'h5A);
    add(1452, 2'd0, 8'd0,   1, 0, 1, 8'h5A);
    add(1453, 2'd0, 8'd0,   1, 0, 0, 8'h5A);
    add(1454, 2'd0, 8'd0,   1, 1, 0, 8'h5A);
    run_tv();

    // All four requested: round robin with seamless cadence.
    do_reset();
    start(4'b1111);
    cad_on = 1'b1;
    cad_bad = 0;
    add(1451, 2'd0, 8'd131, 1, 0, 0, 8'h5A);
    add(1452, 2'd1, 8'd0,   1, 0, 1, 8'h5A);
    add(1454, 2'd1, 8'd0,   1, 1, 0, 8'hB1);
    add(2782, 2'd1, 8'd120, 1, 0, 0, 8'hB1);
    add(2783, 2'd2, 8'd0,   1, 0, 1, 8'hB1);
    add(2785, 2'd2, 8'd0,   1, 1, 0, 8'hC2);
    add(3750, 2'd2, 8'd87,  1, 0, 0, 8'hC2);
    add(3751, 2'd3, 8'd0,   1, 0, 1, 8'hC2);
    add(4355, 2'd3, 8'd54,  1, 0, 0, 8'hD3);
    add(4356, 2'd0, 8'd0,   1, 0, 1, 8'hD3);
    add(4358, 2'd0, 8'd0,   1, 1, 0, 8'h5A);
    run_tv();
    cad_on = 1'b0;
    cmp("cadence_errors", 32'(cad_bad), 32'd0);

    // Request change mid-waveform does not cut it short.
    do_reset();
    start(4'b0010);
    adv_to(0);
    chk(2'd1, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    adv_to(100);
    req = 4'b1010;
    adv_to(1330);
    chk(2'd1, 8'd120, 1'b1, 1'b0, 1'b0, 8'hB1);
    adv_to(1331);
    chk(2'd3, 8'd0, 1'b1, 1'b0, 1'b1, 8'hB1);
    adv_to(1333);
    chk(2'd3, 8'd0, 1'b1, 1'b1, 1'b0, 8'hD3);
    adv_to(1935);
    chk(2'd3, 8'd54, 1'b1, 1'b0, 1'b0, 8'hD3);
    adv_to(1936);
    chk(2'd1, 8'd0, 1'b1, 1'b0, 1'b1, 8'hD3);
    adv_to(2000);
    req = 4'b0000;
    adv_to(3266);
    chk(2'd1, 8'd120, 1'b1, 1'b0, 1'b0, 8'hB1);
    adv_to(3267);
    chk(2'd1, 8'd0, 1'b0, 1'b0, 1'b1, 8'hB1);
    adv_to(3300);
    chk(2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'hB1);

    // Output mask gates the captured sample.
    do_reset();
    mask = 4'b1110;
    start(4'b0001);
    adv_to(2);
    chk(2'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'h00);
    adv_to(5);
    mask = 4'b1111;
    adv_to(12);
    chk(2'd0, 8'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    adv_to(13);
    chk(2'd0, 8'd1, 1'b1, 1'b1, 1'b0, 8'h5A);

    // Enable drop mid-waveform, then re-enable.
    do_reset();
    start(4'b0100);
    adv_to(445);
    chk(2'd2, 8'd40, 1'b1, 1'b0, 1'b0, 8'hC2);
    enable = 1'b0;
    adv_to(446);
    cmp("drop_busy", 32'(busy), 32'd0);
    cmp("drop_addr", 32'(rom_addr), 32'd0);
    cmp("drop_sample_out", 32'(sample_out), 32'd0);
    cmp("drop_wrap", 32'(wrap), 32'd0);
    cmp("drop_valid", 32'(sample_valid), 32'd0);
    req = 4'b1111;
    enable = 1'b1;
    adv_to(447);
    chk(2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset between edges.
    do_reset();
    start(4'b0001);
    adv_to(20);
    chk(2'd0, 8'd1, 1'b1, 1'b0, 1'b0, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk(2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    req = 4'b1000;
    enable = 1'b1;
    rst_n = 1'b1;
    cyc = -1;
    adv_to(0);
    chk(2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
